// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_pkg
// Purpose  : Shared constants for the ID/EX pipeline register: control-bundle
//            bit positions, opcode encodings and operand-usage helpers.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

  // Width of the decoded control bundle
  localparam int CTRL_W = 8;

  // Bit positions inside the control bundle
  localparam int ALUSRC   = 7;
  localparam int MEMTOREG = 6;
  localparam int REGWRITE = 5;
  localparam int MEMREAD  = 4;
  localparam int MEMWRITE = 3;
  localparam int BRANCH   = 2;
  localparam int ALUOP1   = 1;
  localparam int ALUOP0   = 0;

  // Opcodes that matter for operand-usage qualification
  typedef enum logic [6:0] {
    OP_R_TYPE = 7'b0110011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  // Only LUI, AUIPC and JAL ignore rs1
  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  // Only R-type, stores and branches read rs2; elsewhere those bits are immediate
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R_TYPE) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Bundle of ID-side inputs and EX-side outputs of the ID/EX stage.
//            master = surrounding pipeline, slave = the stage itself.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) ();

  // ID side
  logic              valid_in;
  logic [6:0]        opcode_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [RA_W-1:0]   rs1_in;
  logic [RA_W-1:0]   rs2_in;
  logic [RA_W-1:0]   rd_in;
  logic [XLEN-1:0]   rs1_data_in;
  logic [XLEN-1:0]   rs2_data_in;
  logic [XLEN-1:0]   imm_in;
  logic [XLEN-1:0]   pc_in;
  logic [3:0]        funct_in;
  logic              flush_in;
  logic              hold_in;

  // EX side
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [RA_W-1:0]   rs1_out;
  logic [RA_W-1:0]   rs2_out;
  logic [RA_W-1:0]   rd_out;
  logic [XLEN-1:0]   rs1_data_out;
  logic [XLEN-1:0]   rs2_data_out;
  logic [XLEN-1:0]   imm_out;
  logic [XLEN-1:0]   pc_out;
  logic [3:0]        funct_out;
  logic              stall_out;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output valid_in, opcode_in, ctrl_in, rs1_in, rs2_in, rd_in,
           rs1_data_in, rs2_data_in, imm_in, pc_in, funct_in,
           flush_in, hold_in,
    input  valid_out, ctrl_out, rs1_out, rs2_out, rd_out,
           rs1_data_out, rs2_data_out, imm_out, pc_out, funct_out,
           stall_out, stall_count
  );

  modport slave (
    input  valid_in, opcode_in, ctrl_in, rs1_in, rs2_in, rd_in,
           rs1_data_in, rs2_data_in, imm_in, pc_in, funct_in,
           flush_in, hold_in,
    output valid_out, ctrl_out, rs1_out, rs2_out, rd_out,
           rs1_data_out, rs2_data_out, imm_out, pc_out, funct_out,
           stall_out, stall_count
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_hazard_detect
// Purpose  : Combinational load-use hazard check between the instruction in
//            ID and a load sitting in EX. Writes to x0 never hazard.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  output logic            haz
);

  logic ex_load;
  logic rs1_hit;
  logic rs2_hit;

  // A real load in EX with a non-zero destination is the only producer we wait on
  assign ex_load = ex_valid & ex_mem_read & (ex_rd != '0);

  // Only operands the ID instruction actually reads can create a dependency
  assign rs1_hit = uses_rs1(id_opcode) & (id_rs1 == ex_rd);
  assign rs2_hit = uses_rs2(id_opcode) & (id_rs2 == ex_rd);

  assign haz = ex_load & id_valid & (rs1_hit | rs2_hit);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register. Latches the control bundle and datapath
//            fields, inserts one bubble per load-use hazard, honours flush and
//            hold, and counts inserted bubbles with a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [RA_W-1:0]   ex_rs1;
  logic [RA_W-1:0]   ex_rs2;
  logic [RA_W-1:0]   ex_rd;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_pc;
  logic [3:0]        ex_funct;
  logic [CNT_W-1:0]  stall_cnt;

  logic haz;
  logic stall;
  logic advance;
  logic bubble;

  id_ex_stage_hazard_detect #(
    .RA_W (RA_W)
  ) u_hazard (
    .id_valid    (bus.valid_in),
    .id_opcode   (bus.opcode_in),
    .id_rs1      (bus.rs1_in),
    .id_rs2      (bus.rs2_in),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[MEMREAD]),
    .ex_rd       (ex_rd),
    .haz         (haz)
  );

  // Flush outranks hold; a hazard only stalls the front end when neither applies
  assign stall   = haz & ~bus.flush_in & ~bus.hold_in;
  assign advance = bus.flush_in | ~bus.hold_in;
  assign bubble  = bus.flush_in | haz;

  // Pipeline register: reset, then flush / hold / hazard bubble / normal load
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_funct    <= '0;
      stall_cnt   <= '0;
    end else if (advance) begin
      // Datapath fields always follow ID; they are don't-care inside a bubble
      ex_rs1      <= bus.rs1_in;
      ex_rs2      <= bus.rs2_in;
      ex_rd       <= bus.rd_in;
      ex_rs1_data <= bus.rs1_data_in;
      ex_rs2_data <= bus.rs2_data_in;
      ex_imm      <= bus.imm_in;
      ex_pc       <= bus.pc_in;
      ex_funct    <= bus.funct_in;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= bus.valid_in;
        // Gating on valid keeps undriven control bits from an idle ID out of EX
        ex_ctrl  <= bus.valid_in ? bus.ctrl_in : '0;
      end
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.valid_out    = ex_valid;
  assign bus.ctrl_out     = ex_ctrl;
  assign bus.rs1_out      = ex_rs1;
  assign bus.rs2_out      = ex_rs2;
  assign bus.rd_out       = ex_rd;
  assign bus.rs1_data_out = ex_rs1_data;
  assign bus.rs2_data_out = ex_rs2_data;
  assign bus.imm_out      = ex_imm;
  assign bus.pc_out       = ex_pc;
  assign bus.funct_out    = ex_funct;
  assign bus.stall_out    = stall;
  assign bus.stall_count  = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. A second instance with a
//            2-bit stall counter shares the stimulus to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] OPLD = 7'b0000011;
  localparam logic [6:0] OPST = 7'b0100011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPLU = 7'b0110111;
  localparam logic [7:0] C_ADD = 8'b0010_0010;
  localparam logic [7:0] C_LW  = 8'b1111_0000;
  localparam logic [7:0] C_SW  = 8'b1000_1000;
  localparam logic [7:0] C_IMM = 8'b1010_0000;
  localparam int K_LOAD = 0;
  localparam int K_BUB  = 1;
  localparam int K_HOLD = 2;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [7:0]  c;
    logic [4:0]  s1, s2, d;
    logic [31:0] imm;
    logic        fl, ho;
    logic        st;    // expected stall_out while this step is in ID
    int          kind;  // expected effect on EX at the next edge
  } step_t;

  typedef struct packed {
    logic [95:0] val;
    logic [95:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;
  exp_t last_e;
  exp_t sbq[$];

  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(2))  bus_s ();

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus_s.valid_in    = bus.valid_in;
  assign bus_s.opcode_in   = bus.opcode_in;
  assign bus_s.ctrl_in     = bus.ctrl_in;
  assign bus_s.rs1_in      = bus.rs1_in;
  assign bus_s.rs2_in      = bus.rs2_in;
  assign bus_s.rd_in       = bus.rd_in;
  assign bus_s.rs1_data_in = bus.rs1_data_in;
  assign bus_s.rs2_data_in = bus.rs2_data_in;
  assign bus_s.imm_in      = bus.imm_in;
  assign bus_s.pc_in       = bus.pc_in;
  assign bus_s.funct_in    = bus.funct_in;
  assign bus_s.flush_in    = bus.flush_in;
  assign bus_s.hold_in     = bus.hold_in;

  always #5 clk = ~clk;

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic step_t S(input logic v, input logic [6:0] op, input logic [7:0] c,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                              input logic [31:0] imm, input logic fl, input logic ho,
                              input logic st, input int kind);
    step_t t;
    t.v = v; t.op = op; t.c = c; t.s1 = s1; t.s2 = s2; t.d = d;
    t.imm = imm; t.fl = fl; t.ho = ho; t.st = st; t.kind = kind;
    return t;
  endfunction

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : n[1:0];
  endfunction

  // Layout: valid | ctrl | rd | imm | pc | count16 | count2
  function automatic exp_t mk(input logic v, input logic [7:0] c, input logic [4:0] d,
                              input logic [31:0] imm, input logic full);
    exp_t e;
    e.val  = {v, c, d, imm, imm + 32'h1000, 16'(exp_cnt), sat2(exp_cnt)};
    e.mask = full ? {96{1'b1}} : {1'b1, 8'hFF, 5'h0, 64'h0, 16'hFFFF, 2'b11};
    return e;
  endfunction

  function automatic logic [95:0] snap();
    return {bus.valid_out, bus.ctrl_out, bus.rd_out, bus.imm_out, bus.pc_out,
            bus.stall_count, bus_s.stall_count};
  endfunction

  task automatic drive(input step_t t);
    bus.valid_in    = t.v;
    bus.opcode_in   = t.op;
    bus.ctrl_in     = t.c;
    bus.rs1_in      = t.s1;
    bus.rs2_in      = t.s2;
    bus.rd_in       = t.d;
    bus.imm_in      = t.imm;
    bus.pc_in       = t.imm + 32'h1000;
    bus.rs1_data_in = t.imm ^ 32'hA5A5_5A5A;
    bus.rs2_data_in = ~t.imm;
    bus.funct_in    = t.imm[3:0];
    bus.flush_in    = t.fl;
    bus.hold_in     = t.ho;
  endtask

  // Scoreboard producer: expectation for the edge that follows this step
  task automatic push_expect(input step_t t);
    exp_t e;
    case (t.kind)
      K_LOAD:  e = mk(t.v, t.v ? t.c : 8'h00, t.d, t.imm, 1'b1);
      K_BUB: begin
        if (t.st) exp_cnt++;
        e = mk(1'b0, 8'h00, t.d, t.imm, 1'b0);
      end
      default: e = last_e;
    endcase
    last_e = e;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(S(1'b0, OPLD, C_LW, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, K_LOAD));
    tick();
    tick();
    exp_cnt = 0;
    last_e  = '{val: '0, mask: {96{1'b1}}};
    checks++;
    if (snap() !== 96'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", snap());
    end
    checks++;
    if (bus.stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", bus.stall_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    step_t tbl[$];
    exp_t e;
    tbl.push_back(S(1'b1, OPR, C_ADD, 5'd1, 5'd2, 5'd3, 32'h0000_0011, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b0, OPR, 8'bxxxx_xxxx, 5'd3, 5'd3, 5'd4, 32'h0000_0022, 1'b0, 1'b0, 1'b0, K_LOAD));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (bus.stall_out !== tbl[i].st) begin
        errors++;
        $display("FAIL rtype_stall step %0d: got %b want %b", i, bus.stall_out, tbl[i].st);
      end
      push_expect(tbl[i]);
      tick();
      e = sbq.pop_front();
      checks++;
      if ((snap() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL rtype_ex step %0d: got %h want %h", i, snap() & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_load_use();
    step_t tbl[$];
    exp_t e;
    // lw x5 ; add x6,x5,x1 (bubble, then add enters) ; lw x5 ; sw x5 (rs2 hazard)
    tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd5, 32'h0000_0100, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0104, 1'b0, 1'b0, 1'b1, K_BUB));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0104, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd5, 32'h0000_0108, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPST, C_SW,  5'd1, 5'd5, 5'd4, 32'h0000_010C, 1'b0, 1'b0, 1'b1, K_BUB));
    tbl.push_back(S(1'b1, OPST, C_SW,  5'd1, 5'd5, 5'd4, 32'h0000_010C, 1'b0, 1'b0, 1'b0, K_LOAD));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (bus.stall_out !== tbl[i].st) begin
        errors++;
        $display("FAIL load_use_stall step %0d: got %b want %b", i, bus.stall_out, tbl[i].st);
      end
      push_expect(tbl[i]);
      tick();
      e = sbq.pop_front();
      checks++;
      if ((snap() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL load_use_ex step %0d: got %h want %h", i, snap() & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_no_stall();
    step_t tbl[$];
    exp_t e;
    // addi reads only x0 (rs2 bits are immediate); lui ignores rs1; lw x0 never hazards
    tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd5, 32'h0000_0200, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPI,  C_IMM, 5'd0, 5'd5, 5'd7, 32'h0000_0205, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd5, 32'h0000_0208, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPLU, C_IMM, 5'd5, 5'd5, 5'd8, 32'h0000_020C, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd0, 32'h0000_0210, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd0, 5'd0, 5'd1, 32'h0000_0214, 1'b0, 1'b0, 1'b0, K_LOAD));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (bus.stall_out !== tbl[i].st) begin
        errors++;
        $display("FAIL no_stall_stall step %0d: got %b want %b", i, bus.stall_out, tbl[i].st);
      end
      push_expect(tbl[i]);
      tick();
      e = sbq.pop_front();
      checks++;
      if ((snap() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL no_stall_ex step %0d: got %h want %h", i, snap() & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_flush();
    step_t tbl[$];
    exp_t e;
    // Flush beats the hazard: bubble without a count, then an idle ID loads cleanly
    tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd5, 32'h0000_0300, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0304, 1'b1, 1'b0, 1'b0, K_BUB));
    tbl.push_back(S(1'b0, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0308, 1'b0, 1'b0, 1'b0, K_LOAD));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (bus.stall_out !== tbl[i].st) begin
        errors++;
        $display("FAIL flush_stall step %0d: got %b want %b", i, bus.stall_out, tbl[i].st);
      end
      push_expect(tbl[i]);
      tick();
      e = sbq.pop_front();
      checks++;
      if ((snap() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL flush_ex step %0d: got %h want %h", i, snap() & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_hold();
    step_t tbl[$];
    exp_t e;
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd1, 5'd2, 5'd9, 32'h0000_0400, 1'b0, 1'b0, 1'b0, K_LOAD));
    for (int k = 0; k < 3; k++)
      tbl.push_back(S(1'b1, OPLD, C_LW, 5'd7, 5'd7, 5'd7, 32'h0BAD_0000 + k, 1'b0, 1'b1, 1'b0, K_HOLD));
    // Hazard under hold: no bubble, no stall until hold drops
    tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd5, 32'h0000_0410, 1'b0, 1'b0, 1'b0, K_LOAD));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0414, 1'b0, 1'b1, 1'b0, K_HOLD));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0414, 1'b0, 1'b1, 1'b0, K_HOLD));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0414, 1'b0, 1'b0, 1'b1, K_BUB));
    tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0414, 1'b0, 1'b0, 1'b0, K_LOAD));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (bus.stall_out !== tbl[i].st) begin
        errors++;
        $display("FAIL hold_stall step %0d: got %b want %b", i, bus.stall_out, tbl[i].st);
      end
      push_expect(tbl[i]);
      tick();
      e = sbq.pop_front();
      checks++;
      if ((snap() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL hold_ex step %0d: got %h want %h", i, snap() & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_reset_mid_hazard();
    drive(S(1'b1, OPLD, C_LW, 5'd2, 5'd0, 5'd5, 32'h0000_0500, 1'b0, 1'b0, 1'b0, K_LOAD));
    tick();
    drive(S(1'b1, OPR, C_ADD, 5'd5, 5'd1, 5'd6, 32'h0000_0504, 1'b0, 1'b0, 1'b1, K_BUB));
    #1;
    checks++;
    if (bus.stall_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre_stall: got %b want 1", bus.stall_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    last_e  = '{val: '0, mask: {96{1'b1}}};
    checks++;
    if (bus.stall_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall: got %b want 0", bus.stall_out);
    end
    checks++;
    if (snap() !== 96'h0) begin
      errors++;
      $display("FAIL rst_mid_state: got %h want 0", snap());
    end
  endtask

  task automatic test_saturation();
    step_t tbl[$];
    exp_t e;
    // Four hazards: the 2-bit counter must stop at 3 while the 16-bit one reaches 4
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(S(1'b1, OPLD, C_LW,  5'd2, 5'd0, 5'd5, 32'h0000_0600 + 16 * k, 1'b0, 1'b0, 1'b0, K_LOAD));
      tbl.push_back(S(1'b1, OPR,  C_ADD, 5'd5, 5'd5, 5'd6, 32'h0000_0604 + 16 * k, 1'b0, 1'b0, 1'b1, K_BUB));
    end
    tbl.push_back(S(1'b1, OPR, C_ADD, 5'd5, 5'd5, 5'd6, 32'h0000_0700, 1'b0, 1'b0, 1'b0, K_LOAD));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (bus.stall_out !== tbl[i].st) begin
        errors++;
        $display("FAIL sat_stall step %0d: got %b want %b", i, bus.stall_out, tbl[i].st);
      end
      push_expect(tbl[i]);
      tick();
      e = sbq.pop_front();
      checks++;
      if ((snap() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL sat_ex step %0d: got %h want %h", i, snap() & e.mask, e.val & e.mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_no_stall();
    test_flush();
    test_hold();
    test_reset_mid_hazard();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
